// File: rtl/instruction_fetch.sv
// Fetch stage: owns the fetch PC, issues in-order word requests and buffers {pc, instr} for decode.
// Optional IF_MISALIGN_TRAP_EN: a misaligned redirect raises a sticky flag and halts fetch.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_pc,
  output logic [31:0] o_instruction,
  output logic        o_fetch_misaligned
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned SumW = CntW + 2;

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]     pc_mem_q    [FIFO_DEPTH];
  logic [31:0]     instr_mem_q [FIFO_DEPTH];

  logic            halted;
  logic            req_acc;
  logic            rsp_keep;
  logic            push;
  logic            pop;
  logic            flush;
  logic [SumW-1:0] credit_used;
  logic [31:0]     target;

  assign target = {i_redirect_pc[31:2], 2'b00};

`ifdef IF_MISALIGN_TRAP_EN
  typedef enum logic [0:0] {StRun, StHalt} state_e;
  state_e state_q, state_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:  if (i_redirect_valid && (i_redirect_pc[1:0] != 2'b00)) state_d = StHalt;
      StHalt: state_d = StHalt;
    endcase
  end

  always_comb begin
    halted             = (state_q == StHalt);
    o_fetch_misaligned = (state_q == StHalt);
  end
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^i_redirect_pc[1:0];
  assign halted              = 1'b0;
  assign o_fetch_misaligned  = 1'b0;
`endif

  // Every fetch slot is either in flight (live or doomed) or sitting in the buffer.
  assign credit_used      = SumW'(outstanding_q) + SumW'(drop_cnt_q) + SumW'(count_q);
  assign o_imem_req_valid = !i_rst && !halted && (credit_used < SumW'(FIFO_DEPTH));
  assign o_imem_addr      = fetch_pc_q;
  assign req_acc          = o_imem_req_valid && i_imem_req_ready;

  assign o_valid       = (count_q != '0);
  assign o_pc          = pc_mem_q[rd_ptr_q];
  assign o_instruction = instr_mem_q[rd_ptr_q];
  assign pop           = o_valid && i_ready;

  assign flush    = i_redirect_valid || halted;
  assign rsp_keep = i_imem_rsp_valid && (drop_cnt_q == '0);
  assign push     = rsp_keep && !flush;

  always_comb begin
    fetch_pc_d    = req_acc ? fetch_pc_q + 32'd4 : fetch_pc_q;
    rsp_pc_d      = rsp_keep ? rsp_pc_q + 32'd4 : rsp_pc_q;
    outstanding_d = outstanding_q + CntW'(req_acc) - CntW'(rsp_keep);
    drop_cnt_d    = drop_cnt_q - CntW'(i_imem_rsp_valid && (drop_cnt_q != '0));
    if (i_redirect_valid) begin
      // Everything still in flight, including this cycle's request, becomes stale.
      drop_cnt_d    = drop_cnt_q + outstanding_q + CntW'(req_acc) - CntW'(i_imem_rsp_valid);
      outstanding_d = '0;
      fetch_pc_d    = target;
      rsp_pc_d      = target;
    end
  end

  always_comb begin
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d  = count_q + CntW'(push) - CntW'(pop);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      wr_ptr_d = wr_ptr_q + PtrW'(push);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
      instr_mem_q[wr_ptr_q] <= i_imem_rsp_data;
    end
  end

`ifndef SYNTHESIS
  push_not_full_a: assert property (@(posedge i_clk) disable iff (i_rst)
    !(push && (count_q == CntW'(FIFO_DEPTH))));
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch: tagged in-order memory model plus expected decode queue.
module tb_instruction_fetch;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam int unsigned Depth   = 2;

  logic        i_clk;
  logic        i_rst;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [31:0] o_imem_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_pc;
  logic [31:0] o_instruction;
  logic        o_fetch_misaligned;

  instruction_fetch #(
    .RESET_PC  (ResetPc),
    .FIFO_DEPTH(Depth)
  ) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .o_imem_req_valid  (o_imem_req_valid),
    .i_imem_req_ready  (i_imem_req_ready),
    .o_imem_addr       (o_imem_addr),
    .i_imem_rsp_valid  (i_imem_rsp_valid),
    .i_imem_rsp_data   (i_imem_rsp_data),
    .i_redirect_valid  (i_redirect_valid),
    .i_redirect_pc     (i_redirect_pc),
    .o_valid           (o_valid),
    .i_ready           (i_ready),
    .o_pc              (o_pc),
    .o_instruction     (o_instruction),
    .o_fetch_misaligned(o_fetch_misaligned)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] addr;
    bit          dead;
    int unsigned due;
  } mreq_t;

  int unsigned n_vec;
  int unsigned n_err;
  int unsigned n_pops;
  int unsigned cyc;
  int unsigned last_due;
  int unsigned lat_min;
  int unsigned lat_max;
  mreq_t       mem_q[$];
  mreq_t       cur;
  bit          cur_v;
  logic [63:0] exp_fifo[$];
  logic [31:0] exp_req_pc;
  bit          halted_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
  endfunction

  task automatic model_reset();
    mem_q.delete();
    exp_fifo.delete();
    cur_v      = 1'b0;
    exp_req_pc = ResetPc;
    halted_m   = 1'b0;
    cyc        = 0;
    last_due   = 0;
  endtask

  task automatic apply_reset();
    i_rst            = 1'b1;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = '0;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = '0;
    #1;
    check_eq("rst_req_valid", 32'(o_imem_req_valid), 32'd0);
    check_eq("rst_o_valid", 32'(o_valid), 32'd0);
    check_eq("rst_o_pc", o_pc, 32'd0);
    check_eq("rst_o_instr", o_instruction, 32'd0);
    check_eq("rst_misaligned", 32'(o_fetch_misaligned), 32'd0);
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    model_reset();
  endtask

  // One clock: check outputs at the negedge, advance the model across the posedge.
  task automatic step();
    bit          acc;
    bit          popv;
    bit          exp_rv;
    int unsigned d;
    @(negedge i_clk);
    exp_rv = !halted_m && ((exp_fifo.size() + mem_q.size() + int'(cur_v)) < int'(Depth));
    check_eq("req_valid", 32'(o_imem_req_valid), 32'(exp_rv));
    check_eq("o_valid", 32'(o_valid), 32'(exp_fifo.size() != 0));
    check_eq("misaligned", 32'(o_fetch_misaligned), 32'(halted_m));
    acc  = o_imem_req_valid && i_imem_req_ready;
    popv = o_valid && i_ready;
    if (acc) begin
      check_eq("imem_addr", o_imem_addr, exp_req_pc);
      d = cyc + $urandom_range(lat_max, lat_min);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mem_q.push_back('{addr: exp_req_pc, dead: 1'b0, due: d});
      exp_req_pc = exp_req_pc + 32'd4;
    end
    if (popv) begin
      if (exp_fifo.size() == 0) begin
        check_eq("pop_when_empty", 32'd1, 32'd0);
      end else begin
        check_eq("o_pc", o_pc, exp_fifo[0][63:32]);
        check_eq("o_instruction", o_instruction, exp_fifo[0][31:0]);
        void'(exp_fifo.pop_front());
        n_pops++;
      end
    end
    if (cur_v && !cur.dead && !i_redirect_valid && !halted_m) begin
      exp_fifo.push_back({cur.addr, mem_word(cur.addr)});
    end
    if (i_redirect_valid) begin
      exp_fifo.delete();
      foreach (mem_q[i]) mem_q[i].dead = 1'b1;
      exp_req_pc = {i_redirect_pc[31:2], 2'b00};
`ifdef IF_MISALIGN_TRAP_EN
      if (i_redirect_pc[1:0] != 2'b00) halted_m = 1'b1;
`endif
    end
    if (halted_m) exp_fifo.delete();
    @(posedge i_clk);
    #1;
    cyc++;
    cur_v = 1'b0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      cur   = mem_q.pop_front();
      cur_v = 1'b1;
    end
    i_imem_rsp_valid = cur_v;
    i_imem_rsp_data  = cur_v ? mem_word(cur.addr) : $urandom();
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    i_redirect_valid = 1'b1;
    i_redirect_pc    = pc;
    step();
    i_redirect_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_pops = 0;
    i_imem_req_ready = 1'b1;
    i_ready          = 1'b1;
    lat_min = 1; lat_max = 1;
    apply_reset();

    // Streaming with 1-cycle memory and an always-ready decode.
    repeat (10) step();

    // Decode stalled: buffer fills with pc 0x0/0x4, then credit runs out.
    apply_reset();
    i_ready = 1'b0;
    repeat (10) step();
    check_eq("stall_head_pc", o_pc, 32'h0);
    check_eq("stall_o_valid", 32'(o_valid), 32'd1);
    check_eq("stall_credit", 32'(o_imem_req_valid), 32'd0);
    i_ready = 1'b1;
    repeat (8) step();

    // Memory refusing requests: address and valid hold.
    apply_reset();
    i_imem_req_ready = 1'b0;
    repeat (5) begin
      step();
      check_eq("hold_addr", o_imem_addr, 32'h0);
      check_eq("hold_req_valid", 32'(o_imem_req_valid), 32'd1);
    end
    i_imem_req_ready = 1'b1;
    repeat (6) step();

    // Redirect with two requests outstanding on a 3-cycle memory.
    apply_reset();
    lat_min = 3; lat_max = 3;
    step();
    step();
    redirect_to(32'h0000_0100);
    repeat (12) step();

    // Redirect coinciding with a response and an accepted request.
    apply_reset();
    lat_min = 1; lat_max = 1;
    step();
    check_eq("coinc_rsp", 32'(i_imem_rsp_valid), 32'd1);
    check_eq("coinc_req", 32'(o_imem_req_valid), 32'd1);
    redirect_to(32'h0000_0200);
    repeat (8) step();

    // Misaligned redirect target.
    apply_reset();
    step();
    step();
    redirect_to(32'h0000_0102);
`ifdef IF_MISALIGN_TRAP_EN
    repeat (6) begin
      step();
      check_eq("halt_flag", 32'(o_fetch_misaligned), 32'd1);
      check_eq("halt_no_req", 32'(o_imem_req_valid), 32'd0);
    end
`else
    check_eq("aligned_target", o_imem_addr, 32'h0000_0100);
    repeat (6) step();
`endif

    // Address wrap at the top of the space.
    apply_reset();
    redirect_to(32'hFFFF_FFF8);
    repeat (10) step();

    // Randomized traffic with a reset in the middle.
    apply_reset();
    lat_min = 1; lat_max = 4;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) apply_reset();
      i_imem_req_ready = ($urandom_range(3, 0) != 0);
      i_ready          = ($urandom_range(9, 0) < 7);
      i_redirect_valid = ($urandom_range(39, 0) == 0);
`ifdef IF_MISALIGN_TRAP_EN
      i_redirect_pc    = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
`else
      i_redirect_pc    = $urandom();
`endif
      step();
    end
    i_redirect_valid = 1'b0;
    check_eq("progress", 32'(n_pops > 300), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
